// File: rtl/axis_network_data_upsizer.sv
// axis_network_data_upsizer: packs a byte-wide AXI Stream into 64-bit NoC flits
// (HEADER/BODY/TAIL/HEADER_TAIL) behind a single-flit output register.
module axis_network_data_upsizer #(
    parameter int NocDataWidth = 64,
    parameter int flitTypeSize = 2,
    parameter int KeepEnable   = 0,
    parameter int TIdWidth     = 5,
    parameter int TDestWidth   = 11
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_arstn,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tkeep,
    input  logic [TIdWidth-1:0]     s_axis_tid,
    input  logic [TDestWidth-1:0]   s_axis_tdest,
    output logic [NocDataWidth-1:0] network_flit_o,
    output logic [flitTypeSize-1:0] network_flit_type_o,
    output logic                    network_valid_o,
    input  logic                    network_ready_i
);
    localparam logic [1:0] S_IDLE = 2'd0, S_HDR = 2'd1, S_BODY = 2'd2, S_ZTAIL = 2'd3;
    localparam logic [flitTypeSize-1:0] FT_HEADER = 2'b00, FT_BODY = 2'b01, FT_TAIL = 2'b10, FT_HT = 2'b11;

    logic [1:0]                state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [NocDataWidth-1:0]   buf_q, buf_d, cur;
    logic [TIdWidth-1:0]       tid_q, tid_c;
    logic [TDestWidth-1:0]     tdest_q, tdest_c;
    logic [NocDataWidth-1:0]   flit_q, flit_d;
    logic [flitTypeSize-1:0]   type_q, type_d;
    logic                      valid_q, emit, load_ok, acc, store;
    logic [3:0]                n;
    logic [3:0]                hdr_padd;
    logic [6:0]                tail_padd;

    assign load_ok       = !valid_q | network_ready_i;
    assign s_axis_tready = (state_q != S_ZTAIL) & load_ok;
    assign acc           = s_axis_tvalid & s_axis_tready;
    assign store         = acc & ((KeepEnable == 0) | s_axis_tkeep);
    assign n             = {1'b0, cnt_q} + {3'b000, store};
    // Incoming byte merged into the held bytes at its slot; unwritten slots stay zero as padding.
    assign cur           = buf_q | (store ? {{(NocDataWidth-8){1'b0}}, s_axis_tdata} << {cnt_q, 3'b000} : '0);
    // The first beat of a packet can complete a HEADER_TAIL, so use the live tid/tdest in IDLE.
    assign tid_c         = (state_q == S_IDLE) ? s_axis_tid : tid_q;
    assign tdest_c       = (state_q == S_IDLE) ? s_axis_tdest : tdest_q;
    assign hdr_padd      = n[2] ? 4'b0000 : 4'b0001 << n[1:0];
    assign tail_padd     = 7'b0000001 << n[2:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        emit    = 1'b0;
        flit_d  = flit_q;
        type_d  = type_q;
        case (state_q)
            S_IDLE, S_HDR: if (acc) begin
                flit_d  = {tdest_c, 11'b0, tid_c, s_axis_tlast, hdr_padd, cur[31:0]};
                type_d  = s_axis_tlast ? FT_HT : FT_HEADER;
                emit    = s_axis_tlast | (n == 4'd4);
                state_d = s_axis_tlast ? S_IDLE : (n == 4'd4) ? S_BODY : S_HDR;
                cnt_d   = emit ? 3'd0 : n[2:0];
                buf_d   = emit ? '0 : cur;
            end
            S_BODY: if (acc) begin
                flit_d  = (n == 4'd8) ? cur : {1'b1, tail_padd, cur[55:0]};
                type_d  = (n == 4'd8) ? FT_BODY : FT_TAIL;
                emit    = s_axis_tlast | (n == 4'd8);
                state_d = !s_axis_tlast ? S_BODY : (n == 4'd8) ? S_ZTAIL : S_IDLE;
                cnt_d   = emit ? 3'd0 : n[2:0];
                buf_d   = emit ? '0 : cur;
            end
            default: if (load_ok) begin
                flit_d  = {1'b1, 7'b0000001, 56'b0};
                type_d  = FT_TAIL;
                emit    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            tid_q   <= '0;
            tdest_q <= '0;
            flit_q  <= '0;
            type_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            if (acc && state_q == S_IDLE) begin
                tid_q   <= s_axis_tid;
                tdest_q <= s_axis_tdest;
            end
            if (emit) begin
                flit_q <= flit_d;
                type_q <= type_d;
            end
            valid_q <= emit | (valid_q & !network_ready_i);
        end
    end

    assign network_flit_o      = flit_q;
    assign network_flit_type_o = type_q;
    assign network_valid_o     = valid_q;
endmodule

// File: tb/tb_axis_network_data_upsizer.sv
// tb_axis_network_data_upsizer: directed and random packets against a packet-level flit model,
// with hold-stability, latency, ZTAIL back-pressure and async-reset checks.
module tb_axis_network_data_upsizer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tkeep;
    logic [4:0]  s_axis_tid;
    logic [10:0] s_axis_tdest;
    logic [63:0] network_flit_o;
    logic [1:0]  network_flit_type_o;
    logic        network_valid_o, network_ready_i;

    always #5 clk = ~clk;

    axis_network_data_upsizer #(.KeepEnable(1)) dut (
        .s_axis_aclk(clk), .s_axis_arstn(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
        .network_flit_o(network_flit_o), .network_flit_type_o(network_flit_type_o),
        .network_valid_o(network_valid_o), .network_ready_i(network_ready_i)
    );

    int n_chk = 0, n_fail = 0;
    logic [65:0] exp_q[$];
    logic [7:0]  bd[$], kept[$];
    bit          bk[$];
    int          rdy_mode = 0;
    bit          abort = 0, lo_en = 0, held = 0;
    int          lo_cnt = 0;
    logic [65:0] held_v;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flits for one packet derived from the kept-byte count: header takes up to 4,
    // bodies take groups of 8, the remaining 0..7 go into a TAIL.
    function automatic void model(input logic [4:0] tid, input logic [10:0] dst);
        int n = kept.size();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 4 && i < n; i++) f[8*i +: 8] = kept[i];
        f[63:53] = dst;
        f[41:37] = tid;
        if (n <= 4) begin
            f[36] = 1'b1;
            f[35:32] = (n == 4) ? 4'b0000 : 4'(1 << n);
            exp_q.push_back({2'b11, f});
        end else begin
            int rem = n - 4;
            exp_q.push_back({2'b00, f});
            for (int b = 0; b < rem / 8; b++) begin
                f = '0;
                for (int i = 0; i < 8; i++) f[8*i +: 8] = kept[4 + 8*b + i];
                exp_q.push_back({2'b01, f});
            end
            f = '0;
            for (int i = 0; i < rem % 8; i++) f[8*i +: 8] = kept[4 + 8*(rem/8) + i];
            f[62:56] = 7'(1 << (rem % 8));
            f[63] = 1'b1;
            exp_q.push_back({2'b10, f});
        end
    endfunction

    task automatic drive(input logic [7:0] d, input bit k, input bit l, input bit first,
                         input logic [4:0] tid, input logic [10:0] dst);
        bit acc = 0;
        int t = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tid    = first ? tid : 5'($urandom);
        s_axis_tdest  = first ? dst : 11'($urandom);
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("tready_timeout", 66'(acc), 66'd1);
    endtask

    task automatic send(input logic [4:0] tid, input logic [10:0] dst, input bit gaps);
        kept.delete();
        foreach (bd[i]) if (bk[i]) kept.push_back(bd[i]);
        model(tid, dst);
        foreach (bd[i]) begin
            drive(bd[i], bk[i], i == bd.size() - 1, i == 0, tid, dst);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        bd.delete();
        bk.delete();
    endtask

    task automatic add(input logic [7:0] d, input bit k);
        bd.push_back(d);
        bk.push_back(k);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(tag, 66'(exp_q.size()), 66'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        network_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n || abort) held = 0;
        else begin
            if (lo_en && !s_axis_tready) lo_cnt++;
            if (held) begin
                check("hold_valid", 66'(network_valid_o), 66'd1);
                check("hold_flit", {network_flit_type_o, network_flit_o}, held_v);
            end
            if (network_valid_o && network_ready_i) begin
                if (exp_q.size() == 0) check("extra_flit", 66'(exp_q.size()), 66'd1);
                else check("flit", {network_flit_type_o, network_flit_o}, exp_q.pop_front());
            end
            held = network_valid_o && !network_ready_i;
            held_v = {network_flit_type_o, network_flit_o};
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tlast = 1'b0;
        s_axis_tkeep = 1'b1;
        s_axis_tid = '0;
        s_axis_tdest = '0;
        network_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 66'(network_valid_o), 66'd0);
        check("rst_flit", 66'(network_flit_o), 66'd0);
        check("rst_type", 66'(network_flit_type_o), 66'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tready", 66'(s_axis_tready), 66'd1);
        @(posedge clk);
        #1;

        add(8'h11, 1); add(8'h22, 1); add(8'h33, 1);
        send(5'd3, 11'h005, 0);
        check("t1_latency", 66'(network_valid_o), 66'd1);
        drain("t1_drain");

        for (int i = 0; i < 4; i++) add(8'hA0 + 8'(i), 1);
        send(5'd7, 11'h3A5, 0);
        drain("t2_drain");

        for (int i = 0; i < 15; i++) add(8'(i), 1);
        send(5'd9, 11'h123, 0);
        drain("t3_drain");

        lo_cnt = 0;
        lo_en = 1;
        for (int i = 0; i < 12; i++) add(8'h40 + 8'(i), 1);
        send(5'd1, 11'h7FF, 0);
        drain("t4_drain");
        lo_en = 0;
        check("t4_ztail_tready_low", 66'(lo_cnt), 66'd1);

        lo_cnt = 0;
        lo_en = 1;
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) add(8'h80 + 8'(i), 1);
        fork
            send(5'd21, 11'h456, 0);
            begin
                repeat (10) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain("t5_drain");
        lo_en = 0;
        check("t5_tready_dropped", 66'(lo_cnt > 0), 66'd1);

        add(8'h55, 1); add(8'hEE, 0); add(8'h66, 1);
        send(5'd2, 11'h0F0, 0);
        drain("t6_keep_drain");
        add(8'h99, 0);
        send(5'd4, 11'h00F, 0);
        drain("t6_keep_only_drain");

        abort = 1;
        for (int i = 0; i < 10; i++) drive(8'hC0 + 8'(i), 1, 0, i == 0, 5'd5, 11'h111);
        rdy_mode = 2;
        for (int i = 0; i < 2; i++) drive(8'hD0 + 8'(i), 1, 0, 0, 5'd5, 11'h111);
        s_axis_tvalid = 1'b0;
        #2;
        check("pre_rst_valid", 66'(network_valid_o), 66'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 66'(network_valid_o), 66'd0);
        check("async_rst_flit", 66'(network_flit_o), 66'd0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        abort = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) add(8'hE0 + 8'(i), 1);
        send(5'd6, 11'h222, 0);
        drain("post_rst_drain");

        rdy_mode = 1;
        for (int p = 0; p < 30; p++) begin
            int len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                add(8'($urandom), (i == len - 1) ? 1'b1 : ($urandom_range(0, 4) != 0));
            send(5'($urandom), 11'($urandom), 1);
        end
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
